instr_fetch_unit: RTL and testbench

//   Front-end requester for the combinational instruction memory. Owns the PC:
//   - drives the word address into instr_mem every cycle;
//   - captures the returned instruction with its PC into a small prefetch FIFO;
//   - presents the FIFO head to decode over a valid/ready handshake.

---
 rtl/instr_fetch_unit.sv | 91 +++++++++
 tb/tb_instr_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches from a combinational
// instruction memory, buffers words in a prefetch FIFO and hands them to decode.
module instr_fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_instr_i,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] redirect_pc_i,
   output logic                  if_valid_o,
   input  logic                  if_ready_i,
   output logic [DATA_WIDTH-1:0] if_instr_o,
   output logic [DATA_WIDTH-1:0] if_pc_o,
   output logic                  halted_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

   state_e                  state_q;
   logic                    halted_q;
   logic [DATA_WIDTH-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0]   fifo_instr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   fifo_pc_q    [FIFO_DEPTH];

   logic fifo_empty, deq, can_enq, push, zero_word;
   logic unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

   assign fifo_empty  = (count_q == '0);
   assign if_valid_o  = ~fifo_empty & ~redirect_i;
   assign deq         = if_valid_o & if_ready_i;
   assign if_instr_o  = fifo_empty ? '0 : fifo_instr_q[rd_ptr_q];
   assign if_pc_o     = fifo_empty ? '0 : fifo_pc_q[rd_ptr_q];
   assign imem_addr_o = pc_q;
   assign halted_o    = halted_q;

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign can_enq   = (state_q == S_RUN) & ~redirect_i & ((count_q < DEPTH_C) | deq);
   assign zero_word = (imem_instr_i == '0);
   assign push      = can_enq & ~zero_word;

   always_comb begin
      pc_d    = push ? pc_q + DATA_WIDTH'(4) : pc_q;
      count_d = count_q + CNT_W'(push) - CNT_W'(deq);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_RUN;
         halted_q <= 1'b0;
         pc_q     <= RESET_PC;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (redirect_i) begin
         state_q  <= S_RUN;
         halted_q <= 1'b0;
         pc_q     <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         pc_q    <= pc_d;
         count_q <= count_d;
         if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_instr_i;
            fifo_pc_q[wr_ptr_q]    <= pc_q;
            wr_ptr_q               <= wr_ptr_q + 1'b1;
         end
         if (deq) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (can_enq & zero_word) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order delivery, backpressure,
// redirects, halt on zero word, PC wraparound and reset during activity.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, redirect, ready;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr, imem_instr, if_instr, if_pc;
   logic        if_valid, halted;

   logic        rst_w, ready_w;
   logic [31:0] imem_addr_w, imem_instr_w, if_instr_w, if_pc_w;
   logic        if_valid_w, halted_w;
   logic        redirect_w;
   logic [31:0] redirect_pc_w;

   logic [31:0] mem [16];
   int          n_chk  = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   assign imem_instr   = mem[imem_addr[5:2]];
   assign imem_instr_w = mem[imem_addr_w[5:2]];

   instr_fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .imem_addr_o  (imem_addr),
      .imem_instr_i (imem_instr),
      .redirect_i   (redirect),
      .redirect_pc_i(redirect_pc),
      .if_valid_o   (if_valid),
      .if_ready_i   (ready),
      .if_instr_o   (if_instr),
      .if_pc_o      (if_pc),
      .halted_o     (halted)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk          (clk),
      .rst          (rst_w),
      .imem_addr_o  (imem_addr_w),
      .imem_instr_i (imem_instr_w),
      .redirect_i   (redirect_w),
      .redirect_pc_i(redirect_pc_w),
      .if_valid_o   (if_valid_w),
      .if_ready_i   (ready_w),
      .if_instr_o   (if_instr_w),
      .if_pc_o      (if_pc_w),
      .halted_o     (halted_w)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 | i;
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h0010_0093;
      mem[2] = 32'h0020_0113;
      mem[3] = 32'h0020_81b3;
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
      rst_w = 1'b1; ready_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = '0;

      // in-order streaming after reset
      do_reset();
      #1;
      check("rst_valid",  {31'd0, if_valid}, 32'd0);
      check("rst_halted", {31'd0, halted},   32'd0);
      check("rst_addr",   imem_addr, 32'h0);
      check("rst_pc",     if_pc,     32'h0);
      check("rst_instr",  if_instr,  32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("stream_valid", {31'd0, if_valid}, 32'd1);
         check("stream_pc",    if_pc,    32'(k * 4));
         check("stream_instr", if_instr, mem[k]);
      end

      // backpressure: FIFO fills, PC stalls
      ready = 1'b0;
      do_reset();
      for (int k = 0; k < 5; k++) tick();
      check("bp_valid", {31'd0, if_valid}, 32'd1);
      check("bp_pc",    if_pc,     32'h0);
      check("bp_addr",  imem_addr, 32'h8);
      ready = 1'b1;
      #1;
      check("bp_head0", if_pc, 32'h0);
      tick();
      check("bp_head4", if_pc, 32'h4);
      tick();
      check("bp_head8", if_pc, 32'h8);
      check("bp_instr8", if_instr, mem[2]);

      // redirect while FIFO holds 8 and C
      redirect = 1'b1; redirect_pc = 32'h63;
      #1;
      check("redir_valid_kill", {31'd0, if_valid}, 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      check("redir_addr",   imem_addr, 32'h60);
      check("redir_valid1", {31'd0, if_valid}, 32'd0);
      tick();
      check("redir_valid2", {31'd0, if_valid}, 32'd1);
      check("redir_pc",     if_pc,    32'h60);
      check("redir_instr",  if_instr, mem[8]);

      // back-to-back redirects: last target wins
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_pc = 32'h22;
      tick();
      redirect = 1'b0;
      #1;
      check("redir2_addr", imem_addr, 32'h20);
      tick();
      check("redir2_pc", if_pc, 32'h20);

      // halt on zero word, restart on redirect
      mem[3] = 32'h0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         tick();
         check("halt_pc", if_pc, 32'(k * 4));
      end
      tick();
      check("halt_flag",  {31'd0, halted},   32'd1);
      check("halt_valid", {31'd0, if_valid}, 32'd0);
      check("halt_addr",  imem_addr, 32'hC);
      tick();
      tick();
      check("halt_addr_hold", imem_addr, 32'hC);
      check("halt_flag_hold", {31'd0, halted}, 32'd1);
      redirect = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect = 1'b0;
      #1;
      check("unhalt_flag", {31'd0, halted}, 32'd0);
      check("unhalt_addr", imem_addr, 32'h0);
      tick();
      check("unhalt_pc",    if_pc, 32'h0);
      check("unhalt_valid", {31'd0, if_valid}, 32'd1);
      mem[3] = 32'h0020_81b3;

      // reset wins over redirect with a full FIFO
      ready = 1'b0;
      do_reset();
      for (int k = 0; k < 3; k++) tick();
      check("pre_rst_valid", {31'd0, if_valid}, 32'd1);
      rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      rst = 1'b0; redirect = 1'b0;
      #1;
      check("rst6_valid",  {31'd0, if_valid}, 32'd0);
      check("rst6_addr",   imem_addr, 32'h0);
      check("rst6_halted", {31'd0, halted}, 32'd0);
      check("rst6_pc",     if_pc, 32'h0);

      // PC wraps past the top of the address space
      ready_w = 1'b1;
      tick();
      rst_w = 1'b0;
      #1;
      check("wrap_addr0", imem_addr_w, 32'hFFFF_FFF8);
      tick();
      check("wrap_pc0", if_pc_w, 32'hFFFF_FFF8);
      check("wrap_instr0", if_instr_w, mem[14]);
      tick();
      check("wrap_pc1", if_pc_w, 32'hFFFF_FFFC);
      tick();
      check("wrap_pc2", if_pc_w, 32'h0);
      tick();
      check("wrap_pc3", if_pc_w, 32'h4);
      check("wrap_valid", {31'd0, if_valid_w}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
